demux1_16_1bit_guarded: RTL and testbench
=========================================

Name: demux1_16_1bit_guarded

Overview:
- Routes one serial 1-bit line (e.g. a CAN TX line from a single controller) to one of 16 output lines selected by `sel`.
- All non-selected outputs are held at `def_value` (the recessive / idle level).
- A channel switch is only committed once the input line has been idle for a programmable number of cycles, so a frame in flight is never split across channels.
- Sits on the transmit side, opposite the 16:1 receive-side multiplexer.

Parameters:
- IDLE_CYCLES, default 11: consecutive cycles with input_port == def_value required before the line is considered idle.
- CNT_W, default 8: width of the idle counter. Must satisfy 2^CNT_W > IDLE_CYCLES.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- sel  input  5  requested channel. Values 0..15 select a channel; 16..31 mean "unbind" (no channel).
- def_value  input  1  idle/recessive level driven on unselected outputs.
- input_port  input  1  serial line to distribute.
- output_port  output  16  registered per-channel outputs.
- active_sel  output  5  committed channel; 5'h1F when unbound.
- busy  output  1  high while the line is not idle (idle counter < IDLE_CYCLES).
- sel_pending  output  1  high while a requested switch is waiting for line idle.

Behaviour:
- Reset (rst==0 at a clk edge):
  - output_port = {16{def_value}}
  - active_sel = 5'h1F; state = UNBOUND
  - idle_cnt = 0; busy = 1; sel_pending = 0
- Target normalisation: tgt = (sel < 16) ? sel : 5'h1F.
- Idle counter, each edge:
  - If input_port != def_value, idle_cnt <= 0.
  - Otherwise idle_cnt increments, saturating at IDLE_CYCLES.
  - line_idle = (idle_cnt == IDLE_CYCLES); busy = !line_idle (combinational from the counter register).
- State machine, three states:
  - UNBOUND:
    - tgt != 5'h1F: active_sel <= tgt immediately (no idle guard, since no channel carries traffic); go to BOUND.
    - Otherwise stay.
  - BOUND:
    - tgt == active_sel: stay.
    - tgt != active_sel and line_idle: commit active_sel <= tgt. Go to UNBOUND if tgt == 5'h1F, else stay in BOUND.
    - tgt != active_sel and not line_idle: go to WAIT_IDLE; sel_pending <= 1.
  - WAIT_IDLE:
    - Keep routing to the old active_sel and track the latest tgt; only the final value is committed.
    - tgt reverts to active_sel: return to BOUND, sel_pending <= 0, no commit.
    - line_idle: commit tgt, sel_pending <= 0, go to BOUND or UNBOUND as above.
- Output datapath, registered:
  - output_port[i] <= (active_sel == i) ? input_port : def_value, computed from the current active_sel register.
  - Latency input_port -> output_port is 1 cycle.
  - After a commit at edge n, the new channel carries input from edge n+1. The old channel drops to def_value on the same edge.
  - At no edge are two outputs driven from input_port.
- Simultaneous events:
  - A sel change in the same cycle line_idle becomes true commits at that edge.
  - A def_value change takes effect on all unselected outputs at the next edge, and the idle comparison uses the current def_value.
- Reset mid-frame: all outputs return to def_value on the next edge; any pending switch is discarded.

Optional Feature:
- Macro: DEMUX_FORCE_SWITCH_EN.
- When defined:
  - Adds input port force_sel (1 bit).
  - When force_sel==1 in BOUND or WAIT_IDLE, tgt is committed at that edge regardless of line_idle, and sel_pending is cleared.
  - The idle counter is unaffected.
- When undefined:
  - No force_sel port exists; switching is always idle-guarded.

Test Plan:
1. Reset with def_value=1 -> output_port=16'hFFFF, active_sel=5'h1F, sel_pending=0, busy=1 until 11 idle cycles have elapsed.
2. From UNBOUND, sel=5 with input toggling 0/1 -> active_sel=5 after one edge; output_port[5] follows input_port with 1-cycle latency; all other bits stay 1.
3. Bound to 5 with the line active, sel changes to 9 -> sel_pending=1 and traffic stays on bit 5. After 11 consecutive cycles of input=1, active_sel=9, sel_pending=0, and bit 9 carries traffic from the next edge.
4. In WAIT_IDLE, sel goes 9 -> 12 -> 5 before idle -> returns to BOUND at 5 with no commit and sel_pending=0.
5. Bound to 3, sel=20 with the line idle -> active_sel=5'h1F and output_port=16'hFFFF. A later sel=0 binds immediately without waiting for idle.
6. rst driven low mid-frame while bound to 7 with input=0 -> next edge output_port=16'hFFFF and active_sel=5'h1F. With DEMUX_FORCE_SWITCH_EN, force_sel=1 while busy switches 7 -> 2 in one edge.

Source files
------------

// File: rtl/demux1_16_1bit_guarded.sv
// 1:16 serial-line demux with an idle-guarded channel switch, so a frame in flight is never split.
// Optional DEMUX_FORCE_SWITCH_EN adds a force_sel input that commits a switch without waiting for idle.
module demux1_16_1bit_guarded #(
  parameter int unsigned IDLE_CYCLES = 11,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel,
  input  logic        def_value,
  input  logic        input_port,
`ifdef DEMUX_FORCE_SWITCH_EN
  input  logic        force_sel,
`endif
  output logic [15:0] output_port,
  output logic [4:0]  active_sel,
  output logic        busy,
  output logic        sel_pending
);

  localparam int unsigned N_CH  = 16;
  localparam int unsigned SEL_W = 5;
  localparam logic [SEL_W-1:0] UNBIND   = 5'h1F;
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

  typedef enum logic [1:0] {
    UNBOUND   = 2'd0,
    BOUND     = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idle_cnt;
  logic [SEL_W-1:0]   tgt_c;
  logic [SEL_W-1:0]   active_d;
  logic               pending_d;
  logic               line_idle_c;
  logic               force_c;
  logic               commit_c;
  logic [N_CH-1:0]    out_d;

  // Out-of-range selects collapse onto the single "unbound" code.
  assign tgt_c       = (sel < SEL_W'(N_CH)) ? sel : UNBIND;
  assign line_idle_c = (idle_cnt == IDLE_MAX);
  assign busy        = !line_idle_c;

`ifdef DEMUX_FORCE_SWITCH_EN
  assign force_c = force_sel;
`else
  assign force_c = 1'b0;
`endif

  // Idle counter: cleared by any non-idle bit, saturates at IDLE_CYCLES.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (input_port != def_value) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // State, committed channel and pending flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= UNBOUND;
      active_sel  <= UNBIND;
      sel_pending <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_sel  <= active_d;
      sel_pending <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_sel;
    pending_d = sel_pending;
    commit_c  = 1'b0;
    case (state_q)
      UNBOUND: begin
        // Nothing is routed yet, so binding needs no idle guard.
        if (tgt_c != UNBIND) begin
          active_d = tgt_c;
          state_d  = BOUND;
        end
      end
      BOUND: begin
        if (tgt_c != active_sel) begin
          if (line_idle_c || force_c) begin
            commit_c = 1'b1;
          end else begin
            state_d   = WAIT_IDLE;
            pending_d = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (force_c) begin
          commit_c = 1'b1;
        end else if (tgt_c == active_sel) begin
          state_d   = BOUND;
          pending_d = 1'b0;
        end else if (line_idle_c) begin
          commit_c = 1'b1;
        end
      end
      default: begin
        state_d   = UNBOUND;
        active_d  = UNBIND;
        pending_d = 1'b0;
      end
    endcase
    if (commit_c) begin
      active_d  = tgt_c;
      pending_d = 1'b0;
      state_d   = (tgt_c == UNBIND) ? UNBOUND : BOUND;
    end
  end

  // Only the channel matching the current active_sel register sees the line.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      out_d[i] = (active_sel == SEL_W'(i)) ? input_port : def_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      output_port <= {N_CH{def_value}};
    end else begin
      output_port <= out_d;
    end
  end

endmodule

// File: tb/tb_demux1_16_1bit_guarded.sv
// Scoreboard bench for demux1_16_1bit_guarded: directed vectors push hand-computed expectations,
// a monitor pops and checks them one clock edge later.
module tb_demux1_16_1bit_guarded;

  typedef struct {
    int          step;
    logic [15:0] out;
    logic [4:0]  act;
    logic        pend;
    logic        busy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  sel;
  logic        def_value;
  logic        input_port;
  logic [15:0] output_port;
  logic [4:0]  active_sel;
  logic        busy;
  logic        sel_pending;
`ifdef DEMUX_FORCE_SWITCH_EN
  logic        force_sel;
  logic        force_next;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  demux1_16_1bit_guarded dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .def_value   (def_value),
    .input_port  (input_port),
`ifdef DEMUX_FORCE_SWITCH_EN
    .force_sel   (force_sel),
`endif
    .output_port (output_port),
    .active_sel  (active_sel),
    .busy        (busy),
    .sel_pending (sel_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int step, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input logic r, input logic [4:0] s, input logic i, input logic d,
                     input logic [15:0] eo, input logic [4:0] ea, input logic ep, input logic eb);
    exp_t e;
    @(negedge clk);
    rst        = r;
    sel        = s;
    input_port = i;
    def_value  = d;
`ifdef DEMUX_FORCE_SWITCH_EN
    force_sel  = force_next;
`endif
    step_no++;
    e.step = step_no;
    e.out  = eo;
    e.act  = ea;
    e.pend = ep;
    e.busy = eb;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so every rising edge presents a new response.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("output_port", e.step, output_port, e.out);
      chk("active_sel",  e.step, 16'(active_sel), 16'(e.act));
      chk("sel_pending", e.step, 16'(sel_pending), 16'(e.pend));
      chk("busy",        e.step, 16'(busy), 16'(e.busy));
    end
  end

  initial begin
    rst        = 1'b0;
    sel        = 5'h1F;
    def_value  = 1'b1;
    input_port = 1'b1;
`ifdef DEMUX_FORCE_SWITCH_EN
    force_sel  = 1'b0;
    force_next = 1'b0;
`endif

    // Reset, then the idle counter fills: busy drops once 11 idle edges have passed.
    cyc(0, 5'd31, 1, 1, 16'hFFFF, 5'h1F, 0, 1);
    cyc(0, 5'd31, 1, 1, 16'hFFFF, 5'h1F, 0, 1);
    for (int k = 1; k <= 12; k++) cyc(1, 5'd31, 1, 1, 16'hFFFF, 5'h1F, 0, logic'(k < 11));

    // Bind to 5 from UNBOUND immediately; bit 5 follows the line one edge late.
    cyc(1, 5'd5, 0, 1, 16'hFFFF, 5'd5, 0, 1);
    cyc(1, 5'd5, 1, 1, 16'hFFFF, 5'd5, 0, 1);
    cyc(1, 5'd5, 0, 1, 16'hFFDF, 5'd5, 0, 1);
    cyc(1, 5'd5, 1, 1, 16'hFFFF, 5'd5, 0, 1);
    cyc(1, 5'd5, 0, 1, 16'hFFDF, 5'd5, 0, 1);

    // Pending request 9 -> 12 -> back to 5 while busy: returns to BOUND with no commit.
    cyc(1, 5'd9,  0, 1, 16'hFFDF, 5'd5, 1, 1);
    cyc(1, 5'd12, 1, 1, 16'hFFFF, 5'd5, 1, 1);
    cyc(1, 5'd5,  0, 1, 16'hFFDF, 5'd5, 0, 1);
    cyc(1, 5'd5,  1, 1, 16'hFFFF, 5'd5, 0, 1);

    // Request 9 while busy: waits 11 idle edges, commits on the next, then bit 9 carries traffic.
    cyc(1, 5'd9, 0, 1, 16'hFFDF, 5'd5, 1, 1);
    for (int k = 1; k <= 11; k++) cyc(1, 5'd9, 1, 1, 16'hFFFF, 5'd5, 1, logic'(k < 11));
    cyc(1, 5'd9, 1, 1, 16'hFFFF, 5'd9, 0, 0);
    cyc(1, 5'd9, 0, 1, 16'hFDFF, 5'd9, 0, 1);
    cyc(1, 5'd9, 1, 1, 16'hFFFF, 5'd9, 0, 1);

    // Line goes idle; switch to 3, unbind via sel=20, then rebind to 0 without waiting.
    for (int k = 1; k <= 10; k++) cyc(1, 5'd9, 1, 1, 16'hFFFF, 5'd9, 0, logic'(k < 10));
    cyc(1, 5'd3,  1, 1, 16'hFFFF, 5'd3,  0, 0);
    cyc(1, 5'd20, 1, 1, 16'hFFFF, 5'h1F, 0, 0);
    cyc(1, 5'd20, 0, 1, 16'hFFFF, 5'h1F, 0, 1);
    cyc(1, 5'd0,  0, 1, 16'hFFFF, 5'd0,  0, 1);
    cyc(1, 5'd0,  0, 1, 16'hFFFE, 5'd0,  0, 1);

    // def_value flips to 0: unselected outputs follow at the next edge, idle compare uses new level.
    cyc(1, 5'd0, 0, 0, 16'h0000, 5'd0, 0, 1);
    cyc(1, 5'd0, 1, 0, 16'h0001, 5'd0, 0, 1);

    // Back to def_value=1, move to 7 through the idle guard, then reset mid-frame.
    cyc(1, 5'd0, 1, 1, 16'hFFFF, 5'd0, 0, 1);
    for (int k = 1; k <= 11; k++)
      cyc(1, 5'd7, 1, 1, 16'hFFFF, (k < 11) ? 5'd0 : 5'd7, logic'(k < 11), logic'(k < 10));
    cyc(1, 5'd7, 0, 1, 16'hFF7F, 5'd7,  0, 1);
    cyc(0, 5'd7, 0, 1, 16'hFFFF, 5'h1F, 0, 1);
    cyc(1, 5'd7, 0, 1, 16'hFFFF, 5'd7,  0, 1);

`ifdef DEMUX_FORCE_SWITCH_EN
    // Forced switch 7 -> 2 while the line is busy.
    cyc(1, 5'd7, 0, 1, 16'hFF7F, 5'd7, 0, 1);
    force_next = 1'b1;
    cyc(1, 5'd2, 0, 1, 16'hFF7F, 5'd2, 0, 1);
    force_next = 1'b0;
    cyc(1, 5'd2, 0, 1, 16'hFFFB, 5'd2, 0, 1);
`endif

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
